// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area sizes, the packed pixel colour type,
// the colour palette, the bounce direction type and a span compare helper.
package vga_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = 3'b000;
  localparam rgb_t RGB_BLUE   = 3'b001;
  localparam rgb_t RGB_YELLOW = 3'b110;

  // Direction of travel along one axis; POS is right (x) or down (y).
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // True when coord lies in [lo, lo + size). Done in 11 bits so lo + size
  // never wraps for positions near the right/bottom edge.
  function automatic logic span_hit(input logic [9:0]  coord,
                                    input logic [9:0]  lo,
                                    input logic [10:0] size);
    logic [10:0] c_ext;
    logic [10:0] lo_ext;
    c_ext  = {1'b0, coord};
    lo_ext = {1'b0, lo};
    return (c_ext >= lo_ext) && (c_ext < lo_ext + size);
  endfunction

endpackage

// File: rtl/bounce_box_renderer_if.sv
// Video bundle between the sync generator and the pixel stage: incoming
// position/enable/raw syncs and outgoing 1-bit colour plus aligned syncs.
interface bounce_box_renderer_if;

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       display_en;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       r;
  logic       g;
  logic       b;
  logic       h_sync_out;
  logic       v_sync_out;

  // Timing source side (generator or bench).
  modport master (
    output h_count, v_count, display_en, h_sync_in, v_sync_in,
    input  r, g, b, h_sync_out, v_sync_out
  );

  // Renderer side.
  modport slave (
    input  h_count, v_count, display_en, h_sync_in, v_sync_in,
    output r, g, b, h_sync_out, v_sync_out
  );

endinterface

// File: rtl/box_axis.sv
// One axis of the bouncing box: position and direction registers plus the
// edge clamp/flip logic, advanced once per frame when enabled.
module box_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int STEP  = 2,
  parameter int INIT  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [9:0] pos,
  output dir_t       dir
);

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] SIZE_W  = 11'(SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [9:0]  INIT_W  = 10'(INIT);
  localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);

  logic [9:0]  pos_reg;
  logic [9:0]  pos_next;
  dir_t        dir_reg;
  dir_t        dir_next;
  logic [10:0] pos_ext;

  assign pos_ext = {1'b0, pos_reg};

  // Position/direction state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg <= INIT_W;
      dir_reg <= DIR_POS;
    end else begin
      pos_reg <= pos_next;
      dir_reg <= dir_next;
    end
  end

  // Next position: step forward, or clamp flush to the edge and turn around
  // when the next step would overshoot.
  always_comb begin
    pos_next = pos_reg;
    dir_next = dir_reg;
    if (advance) begin
      case (dir_reg)
        DIR_POS: begin
          if (pos_ext + SIZE_W + STEP_W > LIMIT_W) begin
            pos_next = MAX_POS;
            dir_next = DIR_NEG;
          end else begin
            pos_next = 10'(pos_ext + STEP_W);
          end
        end
        default: begin
          if (pos_ext < STEP_W) begin
            pos_next = '0;
            dir_next = DIR_POS;
          end else begin
            pos_next = 10'(pos_ext - STEP_W);
          end
        end
      endcase
    end
  end

  assign pos = pos_reg;
  assign dir = dir_reg;

endmodule

// File: rtl/bounce_box_renderer.sv
// Pixel stage behind the hvsync generator: paints a solid box over a
// background, moves it once per frame with edge bounces, and delays the
// syncs so they leave aligned with the colour (2-cycle latency).
module bounce_box_renderer
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_640,
  parameter int   V_ACTIVE  = V_ACTIVE_480,
  parameter int   BOX_SIZE  = 32,
  parameter int   STEP      = 2,
  parameter int   INIT_X    = 100,
  parameter int   INIT_Y    = 60,
  parameter rgb_t BOX_COLOR = RGB_YELLOW,
  parameter rgb_t BG_COLOR  = RGB_BLUE,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pause,
  bounce_box_renderer_if.slave         vid,
  output logic                         frame_tick,
  output logic [9:0]                   box_x,
  output logic [9:0]                   box_y
);

  localparam logic [10:0] BOX_SIZE_W = 11'(BOX_SIZE);
  localparam logic [9:0]  H_END      = 10'(H_ACTIVE);
  localparam logic [9:0]  V_END      = 10'(V_ACTIVE);

  // ------------------------------------------------------------------
  // Reset: assertion reaches every register at once, release is
  // retimed to clk so the first active edge is clean.
  // ------------------------------------------------------------------
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  // Two-flop release synchroniser for the external active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  // ------------------------------------------------------------------
  // Frame boundary and motion
  // ------------------------------------------------------------------
  logic frame_edge;
  logic advance;
  logic frame_tick_reg;
  dir_t dir_x;
  dir_t dir_y;

  // The boundary pixel sits in blanking, so moving here never tears.
  assign frame_edge = (vid.h_count == H_END) && (vid.v_count == V_END);
  assign advance    = frame_edge && !pause;

  // One-cycle frame pulse, emitted whether or not motion is paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_edge;
    end
  end

  assign frame_tick = frame_tick_reg;

  box_axis #(
    .LIMIT (H_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_X)
  ) u_axis_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .pos     (box_x),
    .dir     (dir_x)
  );

  box_axis #(
    .LIMIT (V_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_Y)
  ) u_axis_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .pos     (box_y),
    .dir     (dir_y)
  );

  // ------------------------------------------------------------------
  // Colour pipeline
  // ------------------------------------------------------------------
  logic hit_x_reg;
  logic hit_y_reg;
  logic de_s1_reg;
  rgb_t rgb_reg;
  rgb_t rgb_next;

  // Stage 1: box membership per axis and the delayed display enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_x_reg <= 1'b0;
      hit_y_reg <= 1'b0;
      de_s1_reg <= 1'b0;
    end else begin
      hit_x_reg <= span_hit(vid.h_count, box_x, BOX_SIZE_W);
      hit_y_reg <= span_hit(vid.v_count, box_y, BOX_SIZE_W);
      de_s1_reg <= vid.display_en;
    end
  end

  // Colour select: blank outside the active area regardless of the hit.
  always_comb begin
    rgb_next = RGB_BLACK;
    if (de_s1_reg) begin
      if (hit_x_reg && hit_y_reg) begin
        rgb_next = BOX_COLOR;
      end else begin
        rgb_next = BG_COLOR;
      end
    end
  end

  // Stage 2: registered colour driving the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_reg <= RGB_BLACK;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign vid.r = rgb_reg.r;
  assign vid.g = rgb_reg.g;
  assign vid.b = rgb_reg.b;

  // ------------------------------------------------------------------
  // Sync delay line, matching the two colour stages. Index 0 is hsync,
  // index 1 is vsync.
  // ------------------------------------------------------------------
  logic [1:0] sync_in;
  logic [1:0] sync_out;

  assign sync_in = {vid.v_sync_in, vid.h_sync_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;

    // Two-stage delay; idles at the inactive level while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= SYNC_IDLE;
        s2_reg <= SYNC_IDLE;
      end else begin
        s1_reg <= sync_in[gi];
        s2_reg <= s1_reg;
      end
    end

    assign sync_out[gi] = s2_reg;
  end

  assign vid.h_sync_out = sync_out[0];
  assign vid.v_sync_out = sync_out[1];

endmodule

// File: tb/tb_bounce_box_renderer.sv
// Scoreboard bench for bounce_box_renderer. Two renderers share stimulus:
// unit A starts at (100,60), unit B at (607,447) near the bottom-right corner.
module tb_bounce_box_renderer;
  import vga_pkg::*;

  localparam int K_PIX = 0;
  localparam int K_BOX = 1;
  localparam int K_RST = 2;

  typedef struct {
    int           due;
    int           kind;
    logic [127:0] tag;
    logic [2:0]   rgb_a;
    logic [2:0]   rgb_b;
    logic         hs;
    logic         vs;
    logic         tick;
    logic [9:0]   ax;
    logic [9:0]   ay;
    logic [9:0]   bx;
    logic [9:0]   by;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pause = 1'b0;
  logic tick_a, tick_b;
  logic [9:0] box_x_a, box_y_a, box_x_b, box_y_b;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bounce_box_renderer_if vid_a ();
  bounce_box_renderer_if vid_b ();

  bounce_box_renderer #(.INIT_X(100), .INIT_Y(60)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .vid        (vid_a),
    .frame_tick (tick_a),
    .box_x      (box_x_a),
    .box_y      (box_y_a)
  );

  bounce_box_renderer #(.INIT_X(607), .INIT_Y(447)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .vid        (vid_b),
    .frame_tick (tick_b),
    .box_x      (box_x_b),
    .box_y      (box_y_b)
  );

  // Compare one expectation against both units' current outputs.
  task automatic check(input exp_t e);
    logic ok;
    logic [2:0] ra, rb;
    ra = {vid_a.r, vid_a.g, vid_a.b};
    rb = {vid_b.r, vid_b.g, vid_b.b};
    total++;
    ok = 1'b1;
    if (e.kind == K_PIX || e.kind == K_RST) begin
      if (ra !== e.rgb_a || rb !== e.rgb_b) ok = 1'b0;
      if (vid_a.h_sync_out !== e.hs || vid_b.h_sync_out !== e.hs) ok = 1'b0;
      if (vid_a.v_sync_out !== e.vs || vid_b.v_sync_out !== e.vs) ok = 1'b0;
    end
    if (e.kind == K_BOX || e.kind == K_RST) begin
      if (tick_a !== e.tick || tick_b !== e.tick) ok = 1'b0;
      if (box_x_a !== e.ax || box_y_a !== e.ay) ok = 1'b0;
      if (box_x_b !== e.bx || box_y_b !== e.by) ok = 1'b0;
    end
    if (!ok) begin
      bad++;
      $display("FAIL %0s cyc=%0d: got rgbA=%b rgbB=%b hs=%b/%b vs=%b/%b tick=%b/%b A=(%0d,%0d) B=(%0d,%0d); want rgbA=%b rgbB=%b hs=%b vs=%b tick=%b A=(%0d,%0d) B=(%0d,%0d)",
               e.tag, cyc, ra, rb, vid_a.h_sync_out, vid_b.h_sync_out,
               vid_a.v_sync_out, vid_b.v_sync_out, tick_a, tick_b,
               box_x_a, box_y_a, box_x_b, box_y_b,
               e.rgb_a, e.rgb_b, e.hs, e.vs, e.tick, e.ax, e.ay, e.bx, e.by);
    end else begin
      $display("pass %0s cyc=%0d rgbA=%b rgbB=%b A=(%0d,%0d) B=(%0d,%0d)",
               e.tag, cyc, ra, rb, box_x_a, box_y_a, box_x_b, box_y_b);
    end
  endtask

  // Monitor: away from the active edge, retire every expectation due now.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs);
    vid_a.display_en = de; vid_a.h_count = h; vid_a.v_count = v;
    vid_a.h_sync_in  = hs; vid_a.v_sync_in = vs;
    vid_b.display_en = de; vid_b.h_count = h; vid_b.v_count = v;
    vid_b.h_sync_in  = hs; vid_b.v_sync_in = vs;
  endtask

  task automatic push_pix(input logic [127:0] tag, input logic [2:0] ra,
                          input logic [2:0] rb, input logic hs, input logic vs);
    exp_t e;
    e = '{due: cyc + 2, kind: K_PIX, tag: tag, rgb_a: ra, rgb_b: rb, hs: hs,
          vs: vs, tick: 1'b0, ax: '0, ay: '0, bx: '0, by: '0};
    sb.push_back(e);
  endtask

  task automatic push_box(input logic [127:0] tag, input int delay, input logic tk,
                          input int ax, input int ay, input int bx, input int by);
    exp_t e;
    e = '{due: cyc + delay, kind: K_BOX, tag: tag, rgb_a: 3'b000, rgb_b: 3'b000,
          hs: 1'b1, vs: 1'b1, tick: tk, ax: 10'(ax), ay: 10'(ay),
          bx: 10'(bx), by: 10'(by)};
    sb.push_back(e);
  endtask

  function automatic exp_t reset_exp(input logic [127:0] tag, input int due);
    exp_t e;
    e = '{due: due, kind: K_RST, tag: tag, rgb_a: 3'b000, rgb_b: 3'b000,
          hs: 1'b1, vs: 1'b1, tick: 1'b0, ax: 10'd100, ay: 10'd60,
          bx: 10'd607, by: 10'd447};
    return e;
  endfunction

  // Pixel: drive one cycle and expect the colour two cycles later.
  task automatic pix(input logic [127:0] tag, input logic de, input int h, input int v,
                     input logic hs, input logic vs, input logic [2:0] ra,
                     input logic [2:0] rb);
    step();
    drive(de, 10'(h), 10'(v), hs, vs);
    push_pix(tag, ra, rb, hs, vs);
  endtask

  // One frame boundary cycle followed by an idle cycle.
  task automatic frame(input logic [127:0] tag, input logic chk, input logic chk_after,
                       input int ax, input int ay, input int bx, input int by);
    step();
    drive(1'b0, 10'd640, 10'd480, 1'b1, 1'b1);
    if (chk) push_box(tag, 1, 1'b1, ax, ay, bx, by);
    if (chk_after) push_box("tick_low", 2, 1'b0, ax, ay, bx, by);
    step();
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
  endtask

  initial begin
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
    reset = 1'b0;

    // Reset held for 5 clocks.
    repeat (5) step();
    sb.push_back(reset_exp("reset_hold", cyc));
    step();
    reset = 1'b1;
    repeat (4) step();

    // Colour and latency, with both box positions exercised.
    pix("box_tl",    1'b1, 100,  60, 1'b1, 1'b1, 3'b110, 3'b001);
    pix("right_out", 1'b1, 132,  60, 1'b1, 1'b1, 3'b001, 3'b001);
    pix("box_br",    1'b1, 131,  91, 1'b1, 1'b1, 3'b110, 3'b001);
    pix("left_out",  1'b1,  99,  60, 1'b1, 1'b1, 3'b001, 3'b001);
    pix("below_out", 1'b1, 100,  92, 1'b1, 1'b1, 3'b001, 3'b001);
    pix("b_tl",      1'b1, 607, 447, 1'b1, 1'b1, 3'b001, 3'b110);
    pix("b_br",      1'b1, 638, 478, 1'b1, 1'b1, 3'b001, 3'b110);
    pix("blank_hit", 1'b0, 100,  60, 1'b1, 1'b1, 3'b000, 3'b000);
    pix("hs_pulse",  1'b0,   0,   0, 1'b0, 1'b1, 3'b000, 3'b000);
    pix("hs_back",   1'b0,   0,   0, 1'b1, 1'b1, 3'b000, 3'b000);
    pix("vs_pulse",  1'b0,   0,   0, 1'b1, 1'b0, 3'b000, 3'b000);
    pix("vs_back",   1'b1, 120,  70, 1'b1, 1'b1, 3'b110, 3'b001);
    pix("idle",      1'b0,   0,   0, 1'b1, 1'b1, 3'b000, 3'b000);
    repeat (3) step();

    // First frame: both units move; B clamps into the corner.
    frame("frame1", 1'b1, 1'b1, 102, 62, 608, 448);
    pix("old_tl_bg", 1'b1, 101,  61, 1'b1, 1'b1, 3'b001, 3'b001);
    pix("new_tl",    1'b1, 102,  62, 1'b1, 1'b1, 3'b110, 3'b001);
    pix("b_corner",  1'b1, 639, 479, 1'b1, 1'b1, 3'b001, 3'b110);
    pix("idle2",     1'b0,   0,   0, 1'b1, 1'b1, 3'b000, 3'b000);
    repeat (3) step();

    // Second frame: B has turned around on both axes.
    frame("frame2", 1'b1, 1'b0, 104, 64, 606, 446);

    // Paused for three frames: ticks continue, nothing moves.
    pause = 1'b1;
    frame("pause1", 1'b1, 1'b0, 104, 64, 606, 446);
    frame("pause2", 1'b1, 1'b0, 104, 64, 606, 446);
    frame("pause3", 1'b1, 1'b1, 104, 64, 606, 446);
    pause = 1'b0;

    // Resumed motion; unpaused frame count m continues at 3.
    frame("resume", 1'b1, 1'b0, 106, 66, 604, 444);
    for (int m = 4; m <= 307; m++) begin
      case (m)
        194: frame("m194", 1'b1, 1'b0, 488, 448, 222,  62);
        195: frame("m195", 1'b1, 1'b0, 490, 448, 220,  60);
        196: frame("m196", 1'b1, 1'b0, 492, 446, 218,  58);
        225: frame("m225", 1'b1, 1'b0, 550, 388, 160,   0);
        226: frame("m226", 1'b1, 1'b0, 552, 386, 158,   0);
        227: frame("m227", 1'b1, 1'b0, 554, 384, 156,   2);
        254: frame("m254", 1'b1, 1'b0, 608, 330, 102,  56);
        255: frame("m255", 1'b1, 1'b0, 608, 328, 100,  58);
        256: frame("m256", 1'b1, 1'b0, 606, 326,  98,  60);
        305: frame("m305", 1'b1, 1'b0, 508, 228,   0, 158);
        306: frame("m306", 1'b1, 1'b0, 506, 226,   0, 160);
        307: frame("m307", 1'b1, 1'b1, 504, 224,   2, 162);
        default: frame("run", 1'b0, 1'b0, 0, 0, 0, 0);
      endcase
    end
    repeat (3) step();

    // Mid-frame reset: outputs are live (colour on, syncs low) when reset
    // drops between edges; the reset values must appear with no clock edge.
    drive(1'b1, 10'd100, 10'd60, 1'b0, 1'b0);
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    check(reset_exp("async_reset", cyc));
    step();
    sb.push_back(reset_exp("reset_held", cyc));
    step();
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (4) step();

    // Anything left unretired means the monitor never reached it.
    repeat (4) step();
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %0s: expectation due at cyc=%0d never checked, now cyc=%0d",
               sb[i].tag, sb[i].due, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
